// File: rtl/search_controller.sv
// Search sequencer above the NLFSR tester tree root: walks an inclusive setting range
// into the tree, drains successful settings into a result FIFO and reports counts.
module search_controller #(
   parameter int unsigned SETTING_WIDTH = 9,
   parameter int unsigned RESULT_DEPTH  = 8,
   parameter int unsigned DRAIN_CYCLES  = 16,
   parameter int unsigned COUNT_WIDTH   = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_start,
   input  logic                     cfg_abort,
   input  logic [SETTING_WIDTH-1:0] cfg_first,
   input  logic [SETTING_WIDTH-1:0] cfg_last,
   output logic                     busy,
   output logic                     done,
   output logic                     tree_start,
   output logic [SETTING_WIDTH-1:0] tree_setting,
   input  logic                     tree_idle,
   input  logic                     tree_running,
   input  logic                     tree_success,
   input  logic [SETTING_WIDTH-1:0] tree_setting_out,
   output logic                     tree_rd_en,
   output logic                     result_valid,
   input  logic                     result_ready,
   output logic [SETTING_WIDTH-1:0] result_data,
   output logic [COUNT_WIDTH-1:0]   issued_count,
   output logic [COUNT_WIDTH-1:0]   found_count
);

   localparam int unsigned AW = $clog2(RESULT_DEPTH);
   localparam int unsigned QW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic                     w_launch;

   logic [SETTING_WIDTH-1:0] r_cur;
   logic [SETTING_WIDTH-1:0] r_last;
   logic [COUNT_WIDTH-1:0]   r_issued;
   logic [COUNT_WIDTH-1:0]   r_found;
   logic                     r_start_q;
   logic                     r_rd_en_q;
   logic [QW-1:0]            r_quiet;
   logic                     w_quiet;

   logic [SETTING_WIDTH-1:0] r_mem [RESULT_DEPTH];
   logic [AW:0]              r_wr_ptr;
   logic [AW:0]              r_rd_ptr;
   logic                     w_full;
   logic                     w_empty;
   logic                     w_push;
   logic                     w_pop;

   assign tree_start   = (r_state == S_ISSUE) & tree_idle;
   assign tree_setting = r_cur;
   assign busy         = (r_state == S_ISSUE) | (r_state == S_DRAIN);
   assign done         = (r_state == S_DONE);
   assign issued_count = r_issued;
   assign found_count  = r_found;

   // Tree is quiet only once the last start has had a cycle to show up in its status.
   assign w_quiet = tree_idle & ~tree_running & ~tree_success & ~r_start_q;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cfg_start) begin
               w_launch    = 1'b1;
               w_state_nxt = (cfg_first <= cfg_last) ? S_ISSUE : S_DRAIN;
            end
         end
         S_ISSUE: begin
            if ((tree_start && (r_cur == r_last)) || cfg_abort) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_quiet == QW'(DRAIN_CYCLES)) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cur     <= '0;
         r_last    <= '0;
         r_issued  <= '0;
         r_found   <= '0;
         r_start_q <= 1'b0;
         r_rd_en_q <= 1'b0;
         r_quiet   <= '0;
      end else begin
         r_start_q <= tree_start;
         r_rd_en_q <= tree_rd_en;
         if (w_launch) begin
            r_cur    <= cfg_first;
            r_last   <= cfg_last;
            r_issued <= '0;
            // A result pushed on the launch cycle belongs to the new search.
            r_found  <= COUNT_WIDTH'(w_push);
         end else begin
            if (tree_start) begin
               if (r_cur != r_last) r_cur <= r_cur + SETTING_WIDTH'(1);
               if (r_issued != '1)  r_issued <= r_issued + COUNT_WIDTH'(1);
            end
            if (w_push && (r_found != '1)) r_found <= r_found + COUNT_WIDTH'(1);
         end
         if ((r_state == S_DRAIN) && w_quiet) begin
            if (r_quiet != QW'(DRAIN_CYCLES)) r_quiet <= r_quiet + QW'(1);
         end else begin
            r_quiet <= '0;
         end
      end
   end

   assign w_empty      = (r_wr_ptr == r_rd_ptr);
   assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign tree_rd_en   = tree_success & ~w_full & ~r_rd_en_q;
   assign w_push       = tree_rd_en;
   assign w_pop        = ~w_empty & result_ready;
   assign result_valid = ~w_empty;
   assign result_data  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int unsigned i = 0; i < RESULT_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= tree_setting_out;
            r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: tb/tb_search_controller.sv
// Directed bench for search_controller: tree status driven by hand, results checked
// against hand-computed values with immediate assertions.
module tb_search_controller;

   localparam int unsigned SW = 9;
   localparam int unsigned CW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_start = 1'b0;
   logic          cfg_abort = 1'b0;
   logic [SW-1:0] cfg_first = '0;
   logic [SW-1:0] cfg_last = '0;
   logic          busy;
   logic          done;
   logic          tree_start;
   logic [SW-1:0] tree_setting;
   logic          tree_idle = 1'b1;
   logic          tree_running = 1'b0;
   logic          tree_success = 1'b0;
   logic [SW-1:0] tree_setting_out = '0;
   logic          tree_rd_en;
   logic          result_valid;
   logic          result_ready = 1'b0;
   logic [SW-1:0] result_data;
   logic [CW-1:0] issued_count;
   logic [CW-1:0] found_count;

   int n_vec = 0;
   int n_err = 0;
   int n_wait;

   search_controller #(
      .SETTING_WIDTH(SW),
      .RESULT_DEPTH (2),
      .DRAIN_CYCLES (16),
      .COUNT_WIDTH  (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_start       (cfg_start),
      .cfg_abort       (cfg_abort),
      .cfg_first       (cfg_first),
      .cfg_last        (cfg_last),
      .busy            (busy),
      .done            (done),
      .tree_start      (tree_start),
      .tree_setting    (tree_setting),
      .tree_idle       (tree_idle),
      .tree_running    (tree_running),
      .tree_success    (tree_success),
      .tree_setting_out(tree_setting_out),
      .tree_rd_en      (tree_rd_en),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .result_data     (result_data),
      .issued_count    (issued_count),
      .found_count     (found_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         tick();
         #1;
         n++;
      end
   endtask

   initial begin
      // Reset
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_busy",   32'(busy), 0);
      chk("rst_done",   32'(done), 0);
      chk("rst_start",  32'(tree_start), 0);
      chk("rst_rd_en",  32'(tree_rd_en), 0);
      chk("rst_valid",  32'(result_valid), 0);
      chk("rst_setting", 32'(tree_setting), 0);
      chk("rst_issued", issued_count, 0);
      chk("rst_found",  found_count, 0);

      // Range 5..8 with an always-idle tree
      cfg_first = 9'd5; cfg_last = 9'd8; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      #1;
      chk("r58_busy", 32'(busy), 1);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin tick(); #1; end
         chk("r58_start", 32'(tree_start), 1);
         chk("r58_setting", 32'(tree_setting), 32'(5 + k));
      end
      tick(); #1;
      chk("r58_drain_nostart", 32'(tree_start), 0);
      chk("r58_issued", issued_count, 4);
      chk("r58_drain_busy", 32'(busy), 1);
      wait_done(n_wait);
      chk("r58_done", 32'(done), 1);
      chk("r58_done_latency", 32'(n_wait), 18);
      chk("r58_done_notbusy", 32'(busy), 0);
      tick(); #1;
      chk("r58_done_pulse", 32'(done), 0);
      chk("r58_idle_busy", 32'(busy), 0);

      // Empty range 10..3
      cfg_first = 9'd10; cfg_last = 9'd3; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      #1;
      chk("empty_busy", 32'(busy), 1);
      chk("empty_nostart", 32'(tree_start), 0);
      wait_done(n_wait);
      chk("empty_done", 32'(done), 1);
      chk("empty_latency", 32'(n_wait), 17);
      chk("empty_issued", issued_count, 0);
      tick(); #1;

      // Single all-ones setting, no wrap
      cfg_first = 9'h1FF; cfg_last = 9'h1FF; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      #1;
      chk("ones_start", 32'(tree_start), 1);
      chk("ones_setting", 32'(tree_setting), 32'h1FF);
      tick(); #1;
      chk("ones_nostart", 32'(tree_start), 0);
      chk("ones_nowrap", 32'(tree_setting), 32'h1FF);
      chk("ones_issued", issued_count, 1);
      wait_done(n_wait);
      chk("ones_latency", 32'(n_wait), 18);
      tick(); #1;

      // Three successes into a 2-deep FIFO with consumer stalled
      tree_setting_out = 9'h11; tree_success = 1'b1;
      #1;
      chk("fifo_rd1", 32'(tree_rd_en), 1);
      tick();
      tree_setting_out = 9'h22;
      #1;
      chk("fifo_rd_forced_low", 32'(tree_rd_en), 0);
      chk("fifo_valid", 32'(result_valid), 1);
      chk("fifo_head11", 32'(result_data), 32'h11);
      chk("fifo_found1", found_count, 1);
      tick(); #1;
      chk("fifo_rd2", 32'(tree_rd_en), 1);
      tick();
      tree_setting_out = 9'h33;
      #1;
      chk("fifo_rd_after2", 32'(tree_rd_en), 0);
      chk("fifo_found2", found_count, 2);
      tick(); #1;
      chk("fifo_full_hold", 32'(tree_rd_en), 0);
      chk("fifo_found_held", found_count, 2);
      result_ready = 1'b1;
      #1;
      chk("fifo_out11", 32'(result_data), 32'h11);
      tick(); #1;
      chk("fifo_out22", 32'(result_data), 32'h22);
      chk("fifo_rd3", 32'(tree_rd_en), 1);
      tick();
      tree_success = 1'b0;
      #1;
      chk("fifo_out33", 32'(result_data), 32'h33);
      chk("fifo_found3", found_count, 3);
      tick();
      result_ready = 1'b0;
      #1;
      chk("fifo_empty", 32'(result_valid), 0);

      // Abort after three issues of 0..100, success captured during drain
      cfg_first = 9'd0; cfg_last = 9'd100; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      #1;
      chk("abort_set0", 32'(tree_setting), 0);
      tick(); #1;
      chk("abort_set1", 32'(tree_setting), 1);
      tick();
      cfg_abort = 1'b1;
      #1;
      chk("abort_start_counted", 32'(tree_start), 1);
      tick();
      cfg_abort = 1'b0;
      tree_running = 1'b1; tree_success = 1'b1; tree_setting_out = 9'h55;
      #1;
      chk("abort_nostart", 32'(tree_start), 0);
      chk("abort_issued", issued_count, 3);
      chk("abort_rd_en", 32'(tree_rd_en), 1);
      tick();
      tree_success = 1'b0;
      #1;
      chk("abort_found", found_count, 1);
      chk("abort_data", 32'(result_data), 32'h55);
      tick(); #1;
      chk("abort_running_busy", 32'(busy), 1);
      tick();
      tree_running = 1'b0;
      #1;
      wait_done(n_wait);
      chk("abort_latency", 32'(n_wait), 17);
      chk("abort_issued_final", issued_count, 3);
      tick();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      #1;
      chk("abort_popped", 32'(result_valid), 0);

      // Reset mid-ISSUE with a result held in the FIFO
      tree_setting_out = 9'h77; tree_success = 1'b1;
      tick();
      tree_success = 1'b0;
      #1;
      chk("mid_fifo_loaded", 32'(result_valid), 1);
      cfg_first = 9'd20; cfg_last = 9'd40; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      tick(); tick();
      #1;
      chk("mid_setting22", 32'(tree_setting), 22);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mid_busy", 32'(busy), 0);
      chk("mid_done", 32'(done), 0);
      chk("mid_start", 32'(tree_start), 0);
      chk("mid_rd_en", 32'(tree_rd_en), 0);
      chk("mid_valid", 32'(result_valid), 0);
      chk("mid_setting", 32'(tree_setting), 0);
      chk("mid_issued", issued_count, 0);
      chk("mid_found", found_count, 0);
      cfg_first = 9'd2; cfg_last = 9'd3; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      #1;
      chk("post_set2", 32'(tree_setting), 2);
      tick(); #1;
      chk("post_set3", 32'(tree_setting), 3);
      tick(); #1;
      chk("post_issued", issued_count, 2);
      wait_done(n_wait);
      chk("post_latency", 32'(n_wait), 18);
      tick(); #1;
      chk("post_idle", 32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
